maxpool2d_stream: RTL and testbench
===================================

# maxpool2d_stream

Streaming 2×2 max-pool engine with configurable stride (1 or 2), channel-interleaved input and exact frame bookkeeping, used between convolution stages in the CNN datapath. It consumes one raster-ordered element per accepted cycle. It emits pooled elements in the same channel-interleaved raster order, with one registered cycle of latency, plus a frame-complete pulse. It generalises the fixed single-channel stride-2 pooler to multi-channel feature maps and to stride-1 pooling.

## Interface
- DATA_WIDTH, 32, element width; two's-complement signed.
- IMG_W, 416, input columns per row; must be ≥ 2.
- IMG_H, 416, input rows per frame; must be ≥ 2.
- CHANNELS, 1, elements per pixel, interleaved c0..c(CHANNELS-1); must be ≥ 1.
- STRIDE, 2, pooling stride; legal values 1 or 2.

- Clk  input  1  clock; all state changes on the rising edge.
- Rst  input  1  asynchronous reset, active-high.
- valid_in  input  1  data_in is accepted this cycle.
- data_in  input  DATA_WIDTH  input element.
- valid_out  output  1  single-cycle pulse; data_out carries a new pooled element.
- data_out  output  DATA_WIDTH  pooled element; holds its last value between pulses.
- frame_done  output  1  pulse coincident with the last valid_out of a frame.

## Operation
- Position counters: ch (0..CHANNELS-1), col (0..IMG_W-1), row (0..IMG_H-1).
  - They advance only on valid_in.
  - ch wraps and carries into col; col wraps and carries into row; row wraps to 0 after the last element of a frame.
- Storage:
  - Line delay of IMG_W·CHANNELS elements, giving the same element one row earlier.
  - Column delay of CHANNELS elements on both the live stream and the line-delay output, giving the left neighbours.
  - Both delays shift only on valid_in.
- Window for the accepted element at (row, col, ch): cur, left = (row, col-1, ch), up = (row-1, col, ch), upleft = (row-1, col-1, ch).
- The result is the signed maximum of the 4 elements. On ties any of the tied values may be selected, since they are equal.
- Emission condition, evaluated on the accepted element:
  - STRIDE=2: row odd and col odd. Output map is floor(IMG_W/2) × floor(IMG_H/2) × CHANNELS. A trailing odd column or row is consumed and discarded.
  - STRIDE=1: row ≥ 1 and col ≥ 1. Output map is (IMG_W-1) × (IMG_H-1) × CHANNELS. No padding.
- frame_done asserts with the final emission of a frame:
  - STRIDE=2: window ending at row 2·floor(IMG_H/2)-1, col 2·floor(IMG_W/2)-1, ch CHANNELS-1.
  - STRIDE=1: row IMG_H-1, col IMG_W-1, ch CHANNELS-1.
- Frames stream back-to-back without gaps. Stale line-delay contents at frame start are harmless, because row 0 never emits.

## Timing
- Reset values: valid_out=0, data_out=0, frame_done=0, all counters 0. Line and column delay contents are don't-care.
- Latency: valid_out, data_out and frame_done are registered. They appear in the cycle after the rising edge that accepted the completing element.
- Throughput: one element per cycle. valid_in may deassert for any number of cycles with no loss. When valid_in=0, outputs pulse at most once (the completion from the previous acceptance) and then return to 0.
- No backpressure: the downstream consumer must accept every valid_out.
- Reset mid-frame: counters return to 0 immediately. The next accepted element is treated as (0,0,c0). Any output pulse in flight is cancelled.
- Counter wrap and a new frame's first element in consecutive cycles need no idle cycle.

## Configuration
- MAXPOOL_RELU_EN:
  - Defined: the result is max(window, 0), i.e. fused ReLU; negative maxima are emitted as 0.
  - Undefined: the raw signed maximum is emitted.
  - Timing and counts are identical either way.

## Test plan
- Stride-2 reference frame. Setup: IMG_W=4, IMG_H=4, CHANNELS=1, inputs 0..15 raster, valid_in held high. Required: 4 outputs 5, 7, 13, 15, each one cycle after inputs 5, 7, 13, 15; frame_done with 15.
- Multi-channel, stride 1. Setup: IMG_W=3, IMG_H=2, CHANNELS=2, element value = 10·pixel index + ch. Required: 4 outputs 40, 41, 50, 51; frame_done with 51.
- Gapped input. Setup: the stride-2 case with valid_in toggling every other cycle. Required: same values in the same order; each pulse exactly one cycle after its completing acceptance.
- Signed and ReLU. Setup: 2×2 frame of -5, -3, -8, -1. Required: output -1 without MAXPOOL_RELU_EN; output 0 with it.
- Reset mid-frame. Setup: assert Rst after 6 elements of a 4×4 stride-2 frame, then send a full fresh frame 0..15. Required: no output during reset; exactly 4 outputs 5, 7, 13, 15; frame_done once.
- Back-to-back frames. Setup: two 4×4 stride-2 frames with no gap, second frame = first + 100. Required: outputs 5, 7, 13, 15, 105, 107, 113, 115; two frame_done pulses.

Source files
------------

// File: rtl/maxpool2d_stream.sv
// maxpool2d_stream: streaming 2x2 max-pool, stride 1 or 2, channel-interleaved raster input.
// Define MAXPOOL_RELU_EN to clamp negative maxima to zero (fused ReLU).
module maxpool2d_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_W      = 416,
  parameter int IMG_H      = 416,
  parameter int CHANNELS   = 1,
  parameter int STRIDE     = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);
  localparam int LD = IMG_W * CHANNELS;
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int PW = $clog2(LD);
  logic [CW-1:0] ch_q, ch_d;
  logic [XW-1:0] col_q, col_d;
  logic [YW-1:0] row_q, row_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] line_q [LD];
  logic [DATA_WIDTH-1:0] left_q [CHANNELS];
  logic [DATA_WIDTH-1:0] upleft_q [CHANNELS];
  logic signed [DATA_WIDTH-1:0] cur, left, up, upleft, m0, m1, mx, res;
  logic ch_last, col_last, row_last, emit, last;
  always_comb begin
    ch_last  = ch_q == CW'(CHANNELS - 1);
    col_last = col_q == XW'(IMG_W - 1);
    row_last = row_q == YW'(IMG_H - 1);
    ch_d     = ch_last ? '0 : ch_q + CW'(1);
    col_d    = !ch_last ? col_q : col_last ? '0 : col_q + XW'(1);
    row_d    = !(ch_last && col_last) ? row_q : row_last ? '0 : row_q + YW'(1);
    ptr_d    = ptr_q == PW'(LD - 1) ? '0 : ptr_q + PW'(1);
    cur      = data_in;
    left     = left_q[CHANNELS-1];
    up       = line_q[ptr_q];
    upleft   = upleft_q[CHANNELS-1];
    m0       = cur > left ? cur : left;
    m1       = up > upleft ? up : upleft;
    mx       = m0 > m1 ? m0 : m1;
`ifdef MAXPOOL_RELU_EN
    res      = mx[DATA_WIDTH-1] ? '0 : mx;
`else
    res      = mx;
`endif
    emit     = STRIDE == 2 ? (row_q[0] && col_q[0]) : (row_q != '0 && col_q != '0);
    last     = STRIDE == 2 ? (row_q == YW'(2 * (IMG_H / 2) - 1) && col_q == XW'(2 * (IMG_W / 2) - 1) && ch_last)
                           : (row_last && col_last && ch_last);
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      ch_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      ptr_q      <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= valid_in && emit;
      frame_done <= valid_in && emit && last;
      if (valid_in) begin
        ch_q  <= ch_d;
        col_q <= col_d;
        row_q <= row_d;
        ptr_q <= ptr_d;
        if (emit) data_out <= res;
      end
    end
  // line delay is a circular buffer: the slot read this cycle holds the element one row earlier
  always_ff @(posedge Clk)
    if (valid_in) begin
      line_q[ptr_q] <= data_in;
      left_q[0]     <= data_in;
      upleft_q[0]   <= line_q[ptr_q];
      for (int i = 1; i < CHANNELS; i++) begin
        left_q[i]   <= left_q[i-1];
        upleft_q[i] <= upleft_q[i-1];
      end
    end
endmodule

// File: tb/tb_maxpool2d_stream.sv
// tb_maxpool2d_stream: frame-buffer reference model checked every cycle, plus literal output lists.
module tb_maxpool2d_stream;
`ifdef MAXPOOL_RELU_EN
  localparam bit RELU = 1;
`else
  localparam bit RELU = 0;
`endif
  logic Clk = 0, Rst = 1;
  always #5 Clk = ~Clk;
  logic vi[3];
  logic [31:0] di[3];
  logic ov[3], fd[3];
  logic [31:0] od[3];
  maxpool2d_stream #(.DATA_WIDTH(32), .IMG_W(4), .IMG_H(4), .CHANNELS(1), .STRIDE(2)) ua (
    .Clk(Clk), .Rst(Rst), .valid_in(vi[0]), .data_in(di[0]), .valid_out(ov[0]), .data_out(od[0]), .frame_done(fd[0]));
  maxpool2d_stream #(.DATA_WIDTH(32), .IMG_W(3), .IMG_H(2), .CHANNELS(2), .STRIDE(1)) ub (
    .Clk(Clk), .Rst(Rst), .valid_in(vi[1]), .data_in(di[1]), .valid_out(ov[1]), .data_out(od[1]), .frame_done(fd[1]));
  maxpool2d_stream #(.DATA_WIDTH(32), .IMG_W(2), .IMG_H(2), .CHANNELS(1), .STRIDE(2)) uc (
    .Clk(Clk), .Rst(Rst), .valid_in(vi[2]), .data_in(di[2]), .valid_out(ov[2]), .data_out(od[2]), .frame_done(fd[2]));

  int errs = 0, checks = 0;
  logic signed [31:0] img[3][64];
  int n[3];
  bit ev[3], ed[3];
  logic [31:0] eo[3];
  logic [31:0] qa[$], qb[$], qc[$];
  int dones[3];

  function automatic logic signed [31:0] wmax(input logic signed [31:0] a, b, c, d);
    logic signed [31:0] m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (RELU && m < 0) ? 0 : m;
  endfunction
  function automatic bit emits(input int i, w, c, s);
    int x = (i / c) % w, y = i / (c * w);
    return s == 2 ? (x % 2 == 1 && y % 2 == 1) : (x >= 1 && y >= 1);
  endfunction
  function automatic bit lastw(input int i, w, h, c, s);
    int x = (i / c) % w, y = i / (c * w), k = i % c;
    return k == c - 1 && (s == 2 ? (x == 2 * (w / 2) - 1 && y == 2 * (h / 2) - 1) : (x == w - 1 && y == h - 1));
  endfunction

  task automatic clr(input int k);
    n[k] = 0; ev[k] = 0; ed[k] = 0; eo[k] = 0;
  endtask
  // frame buffer indexed by position-in-frame; window taken from the stored frame
  task automatic step(input int k, w, h, c, s, input logic v, input logic [31:0] d);
    int i = n[k];
    ev[k] = 0; ed[k] = 0;
    if (!v) return;
    img[k][i] = d;
    if (emits(i, w, c, s)) begin
      ev[k] = 1;
      ed[k] = lastw(i, w, h, c, s);
      eo[k] = wmax(img[k][i], img[k][i-c], img[k][i-w*c], img[k][i-w*c-c]);
    end
    n[k] = (i + 1) % (w * h * c);
  endtask
  always @(posedge Clk or posedge Rst) if (Rst) clr(0); else step(0, 4, 4, 1, 2, vi[0], di[0]);
  always @(posedge Clk or posedge Rst) if (Rst) clr(1); else step(1, 3, 2, 2, 1, vi[1], di[1]);
  always @(posedge Clk or posedge Rst) if (Rst) clr(2); else step(2, 2, 2, 1, 2, vi[2], di[2]);

  task automatic chk(input string nm, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, $signed(act), $signed(exp), $time);
    end
  endtask

  always @(negedge Clk)
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("valid_out[%0d]", k), 32'(ov[k]), 32'(ev[k]));
      chk($sformatf("frame_done[%0d]", k), 32'(fd[k]), 32'(ed[k]));
      chk($sformatf("data_out[%0d]", k), od[k], eo[k]);
      if (ov[k]) begin
        if (k == 0) qa.push_back(od[k]);
        else if (k == 1) qb.push_back(od[k]);
        else qc.push_back(od[k]);
      end
      if (fd[k]) dones[k]++;
    end

  task automatic send(input int k, input logic v, input logic [31:0] d);
    @(posedge Clk);
    #1 vi[k] = v; di[k] = d;
  endtask

  initial begin
    int ea[20] = '{5, 7, 13, 15, 5, 7, 13, 15, 5, 7, 13, 15, 5, 7, 13, 15, 105, 107, 113, 115};
    int eb[4] = '{40, 41, 50, 51};
    int sc[8] = '{-5, -3, -8, -1, 3, -2, -7, 1};
    for (int k = 0; k < 3; k++) begin vi[k] = 0; di[k] = 0; dones[k] = 0; end
    repeat (2) @(posedge Clk);
    #1 Rst = 0;
    for (int i = 0; i < 16; i++) send(0, 1, i);
    repeat (3) send(0, 0, 0);
    for (int i = 0; i < 16; i++) begin send(0, 1, i); send(0, 0, 0); end
    for (int i = 0; i < 6; i++) send(0, 1, i);
    @(posedge Clk);
    #1 Rst = 1; vi[0] = 0;
    @(posedge Clk);
    #1 Rst = 0;
    for (int i = 0; i < 16; i++) send(0, 1, i);
    for (int i = 0; i < 16; i++) send(0, 1, i);
    for (int i = 0; i < 16; i++) send(0, 1, 100 + i);
    send(0, 0, 0);
    for (int p = 0; p < 6; p++) for (int c = 0; c < 2; c++) send(1, 1, 10 * p + c);
    send(1, 0, 0);
    for (int i = 0; i < 8; i++) send(2, 1, sc[i]);
    send(2, 0, 0);
    repeat (3) send(0, 0, 0);
    chk("count_a", qa.size(), 20);
    for (int i = 0; i < 20 && i < qa.size(); i++) chk($sformatf("seq_a[%0d]", i), qa[i], ea[i]);
    chk("dones_a", dones[0], 5);
    chk("count_b", qb.size(), 4);
    for (int i = 0; i < 4 && i < qb.size(); i++) chk($sformatf("seq_b[%0d]", i), qb[i], eb[i]);
    chk("dones_b", dones[1], 1);
    chk("count_c", qc.size(), 2);
    if (qc.size() > 0) chk("signed_c0", qc[0], RELU ? 0 : -1);
    if (qc.size() > 1) chk("signed_c1", qc[1], 3);
    chk("dones_c", dones[2], 2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
